usb_crc16_rx_checker: RTL and testbench
=======================================

# usb_crc16_rx_checker

Receive-side CRC16 checker for the endpoint data path. It takes the byte stream of a USB DATA packet after the PID: payload bytes followed by the 2-byte CRC16 field. It forwards only the payload bytes, with the CRC field stripped and a last-byte marker. At the end of each packet it reports CRC pass/fail, payload length and framing errors. It checks the CRC generated by the transmit-side CRC16 logic, using polynomial x^16 + x^15 + x^2 + 1.

## Interface
Parameters:
- MAX_LEN, 1023: maximum legal payload bytes per packet.
- LEN_W, 11: width of len; must hold MAX_LEN.

Ports:
- clk  input  1  rising-edge clock.
- reset_L  input  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  input  1  in_data is valid this cycle. No backpressure; every valid byte is accepted.
- in_data  input  8  packet byte.
- in_last  input  1  qualifies the final byte of the packet (second CRC byte); ignored when in_valid=0.
- in_abort  input  1  discard the current packet (bit-stuff/PID/timeout error upstream).
- out_valid  output  1  payload byte valid.
- out_data  output  8  payload byte.
- out_last  output  1  final payload byte.
- done  output  1  one-cycle pulse: packet status is valid.
- crc_ok  output  1  CRC check passed; held until the next done.
- len  output  LEN_W  payload byte count, saturating at MAX_LEN; held until the next done.
- err_short  output  1  packet had fewer than 2 bytes; held until the next done.
- err_long  output  1  payload exceeded MAX_LEN; held until the next done.

## Operation
- CRC model (CRC-16/USB, reflected form):
  - crc register starts at 0xFFFF at packet start.
  - Per byte: crc ^= byte, then 8 times crc = crc[0] ? (crc>>1)^0xA001 : crc>>1.
  - The transmitter sends ~crc low byte first.
- Check: crc is run over every byte including the two CRC bytes. Pass when the register after the last byte equals residue 0xB001.
- Hold buffer: 2 bytes deep, so the CRC field never reaches the output. Accepting packet byte j (j≥2) emits byte j-2.
- State machine (states name the hold occupancy):
  - EMPTY: in_valid → H1.
  - H1: in_valid → H2. A second byte with in_last → EMPTY with 0 payload bytes.
  - H2: each in_valid emits the oldest held byte.
  - Any in_last → EMPTY.
- in_last with 2 bytes held: the emitted byte carries out_last. That byte is the final payload byte, since the two remaining held bytes are the CRC field.
- in_last in EMPTY (1-byte packet): no output; err_short=1, crc_ok=0, len=0.
- in_last as the second byte: zero-length payload. No output; crc_ok is computed normally (CRC bytes 0x00 0x00 pass).
- len counts emitted payload bytes. On count > MAX_LEN: err_long=1, len saturates at MAX_LEN, bytes are still forwarded, crc_ok is still evaluated.
- in_abort: hold, counter and crc are cleared; state → EMPTY.
  - No done and no out_last for that packet; status outputs keep their previous values.
  - Abort takes priority over in_valid in the same cycle; that byte is dropped.
- A new packet may start the cycle after in_last (back-to-back packets).

## Timing
- Reset (async, reset_L=0): all outputs 0 immediately; state EMPTY; crc=0xFFFF; hold and counter cleared. A packet cut off by reset is lost and gets no done.
- Byte accepted at edge t: the emitted payload byte appears with out_valid=1 in cycle t+1, fully registered. out_valid is never asserted two cycles after one input byte.
- in_last accepted at edge t: done=1 for exactly cycle t+1, aligned with out_last when a payload exists. crc_ok, len, err_short and err_long update in that same cycle.
- Gaps (in_valid=0) may occur anywhere in a packet. State holds, and out_valid=0 during gaps.

## Test plan
- 0x31..0x39 ("123456789") then 0xC8, 0xB4 with in_last → 9 out bytes 0x31..0x39, out_last on 0x39, done next cycle, crc_ok=1, len=9, errors 0.
- Same packet with last byte 0xB5 → same 9 bytes forwarded, crc_ok=0, len=9.
- 0x00, 0x00 with in_last → no out_valid, done, crc_ok=1, len=0. Then single byte 0x12 with in_last → done, err_short=1, crc_ok=0, len=0.
- 5 bytes then in_abort together with a valid byte → no done, no out_last. Next packet, scenario 1 sent back-to-back with 1-cycle gaps, passes exactly as in scenario 1.
- 1100 payload bytes plus correct CRC → 1100 bytes forwarded, err_long=1, len=1023, crc_ok=1.
- reset_L pulsed low mid-packet → outputs 0 asynchronously. Scenario 1 afterward passes.

Source files
------------

// File: rtl/usb_crc16_rx_checker.sv
// usb_crc16_rx_checker
//   Receive-side CRC16 (CRC-16/USB, reflected, poly 0xA001) checker for a USB
//   DATA packet after the PID. Payload bytes are forwarded with the trailing
//   2-byte CRC field stripped by a 2-deep hold buffer; per-packet status is
//   reported with a one-cycle done pulse.
//
// Ports
//   clk        rising-edge clock
//   reset_L    asynchronous active-low reset
//   in_valid   in_data valid (no backpressure)
//   in_data    packet byte
//   in_last    final packet byte (second CRC byte)
//   in_abort   discard current packet; wins over in_valid
//   out_valid  payload byte valid
//   out_data   payload byte
//   out_last   final payload byte
//   done       one-cycle packet status strobe
//   crc_ok     CRC residue matched (held until next done)
//   len        payload byte count, saturating at MAX_LEN (held)
//   err_short  packet shorter than 2 bytes (held)
//   err_long   payload longer than MAX_LEN (held)
//
// state    | meaning
// ST_EMPTY | no bytes held
// ST_H1    | one byte held
// ST_H2    | two bytes held; each new byte pushes the oldest out
module usb_crc16_rx_checker #(
  parameter int MAX_LEN = 1023,
  parameter int LEN_W   = 11
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  input  logic             in_abort,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             done,
  output logic             crc_ok,
  output logic [LEN_W-1:0] len,
  output logic             err_short,
  output logic             err_long
);

  localparam logic [15:0] CRC_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC_RESIDUE = 16'hB001;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {ST_EMPTY, ST_H1, ST_H2} state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_hold0, r_hold1, w_hold0_nxt, w_hold1_nxt;
  logic [15:0]      r_crc, w_crc_nxt, w_crc_byte;
  logic [LEN_W-1:0] r_cnt, w_cnt_nxt, w_len_inc;
  logic             r_over, w_over_nxt, w_long_inc;
  logic             w_out_valid, w_out_last, w_done;
  logic [7:0]       w_out_data;
  logic             w_crc_ok, w_err_short, w_err_long;
  logic [LEN_W-1:0] w_len;

  function automatic logic [15:0] f_crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] v;
    v = c ^ {8'h00, d};
    for (int k = 0; k < 8; k++) begin
      v = v[0] ? ((v >> 1) ^ 16'hA001) : (v >> 1);
    end
    return v;
  endfunction

  assign w_crc_byte = f_crc_byte(r_crc, in_data);
  // Count of emitted bytes including the one being emitted now; r_over
  // remembers that the count already went past MAX_LEN earlier.
  assign w_len_inc  = (r_cnt == LEN_MAX) ? LEN_MAX : r_cnt + LEN_W'(1);
  assign w_long_inc = r_over | (r_cnt == LEN_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_hold0_nxt = r_hold0;
    w_hold1_nxt = r_hold1;
    w_crc_nxt   = r_crc;
    w_cnt_nxt   = r_cnt;
    w_over_nxt  = r_over;
    w_out_valid = 1'b0;
    w_out_data  = out_data;
    w_out_last  = 1'b0;
    w_done      = 1'b0;
    w_crc_ok    = crc_ok;
    w_len       = len;
    w_err_short = err_short;
    w_err_long  = err_long;

    if (in_abort) begin
      w_state_nxt = ST_EMPTY;
      w_hold0_nxt = 8'h00;
      w_hold1_nxt = 8'h00;
      w_crc_nxt   = CRC_INIT;
      w_cnt_nxt   = '0;
      w_over_nxt  = 1'b0;
    end else if (in_valid) begin
      w_crc_nxt = w_crc_byte;
      case (r_state)
        ST_EMPTY: begin
          w_hold0_nxt = in_data;
          w_state_nxt = ST_H1;
          if (in_last) begin
            w_done      = 1'b1;
            w_crc_ok    = 1'b0;
            w_len       = '0;
            w_err_short = 1'b1;
            w_err_long  = 1'b0;
          end
        end
        ST_H1: begin
          w_hold1_nxt = in_data;
          w_state_nxt = ST_H2;
          if (in_last) begin
            w_done      = 1'b1;
            w_crc_ok    = (w_crc_byte == CRC_RESIDUE);
            w_len       = '0;
            w_err_short = 1'b0;
            w_err_long  = 1'b0;
          end
        end
        ST_H2: begin
          w_out_valid = 1'b1;
          w_out_data  = r_hold0;
          w_hold0_nxt = r_hold1;
          w_hold1_nxt = in_data;
          w_cnt_nxt   = w_len_inc;
          w_over_nxt  = w_long_inc;
          if (in_last) begin
            w_out_last  = 1'b1;
            w_done      = 1'b1;
            w_crc_ok    = (w_crc_byte == CRC_RESIDUE);
            w_len       = w_len_inc;
            w_err_short = 1'b0;
            w_err_long  = w_long_inc;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
      // End of packet: the two bytes left in the hold are the CRC field.
      if (in_last) begin
        w_state_nxt = ST_EMPTY;
        w_hold0_nxt = 8'h00;
        w_hold1_nxt = 8'h00;
        w_crc_nxt   = CRC_INIT;
        w_cnt_nxt   = '0;
        w_over_nxt  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) r_state <= ST_EMPTY;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_hold0   <= 8'h00;
      r_hold1   <= 8'h00;
      r_crc     <= CRC_INIT;
      r_cnt     <= '0;
      r_over    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
      done      <= 1'b0;
      crc_ok    <= 1'b0;
      len       <= '0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      r_hold0   <= w_hold0_nxt;
      r_hold1   <= w_hold1_nxt;
      r_crc     <= w_crc_nxt;
      r_cnt     <= w_cnt_nxt;
      r_over    <= w_over_nxt;
      out_valid <= w_out_valid;
      out_data  <= w_out_data;
      out_last  <= w_out_last;
      done      <= w_done;
      crc_ok    <= w_crc_ok;
      len       <= w_len;
      err_short <= w_err_short;
      err_long  <= w_err_long;
    end
  end

endmodule

// File: tb/tb_usb_crc16_rx_checker.sv
// Scoreboard bench for usb_crc16_rx_checker: stimulus pushes expected
// payload bytes and packet status into queues; a negedge monitor pops and
// compares whenever out_valid or done is seen.
module tb_usb_crc16_rx_checker;

  typedef struct packed {
    logic        ok;
    logic [10:0] len;
    logic        es;
    logic        el;
    logic        pl;
  } stat_t;

  logic        clk;
  logic        reset_L;
  logic        in_valid, in_last, in_abort;
  logic [7:0]  in_data;
  logic        out_valid, out_last, done, crc_ok, err_short, err_long;
  logic [7:0]  out_data;
  logic [10:0] len;

  int errors = 0;
  int checks = 0;

  logic [8:0]  byte_q[$];
  stat_t       stat_q[$];
  logic [7:0]  pkt[$];
  logic        prev_fed, prev_last;

  usb_crc16_rx_checker #(.MAX_LEN(1023), .LEN_W(11)) dut (
    .clk(clk), .reset_L(reset_L),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_abort(in_abort),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .done(done), .crc_ok(crc_ok), .len(len),
    .err_short(err_short), .err_long(err_long)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      if ((r[0] ^ d[b]) == 1'b1) r = (r >> 1) ^ 16'hA001;
      else                       r = r >> 1;
    end
    return r;
  endfunction

  // Which input cycles actually delivered a byte / a last byte.
  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      prev_fed  <= 1'b0;
      prev_last <= 1'b0;
    end else begin
      prev_fed  <= in_valid & ~in_abort;
      prev_last <= in_valid & ~in_abort & in_last;
    end
  end

  always @(negedge clk) begin
    if (reset_L) begin
      if (out_valid) begin
        chk("emit_timing", {31'd0, prev_fed}, 32'd1);
        if (byte_q.size() == 0) begin
          chk("unexpected_byte", {23'd0, out_data, out_last}, 32'h1FF);
        end else begin
          logic [8:0] e;
          e = byte_q.pop_front();
          chk("out_data", {24'd0, out_data}, {24'd0, e[8:1]});
          chk("out_last", {31'd0, out_last}, {31'd0, e[0]});
        end
      end else if (out_last) begin
        chk("out_last_no_valid", 32'd1, 32'd0);
      end
      if (done) begin
        chk("done_timing", {31'd0, prev_last}, 32'd1);
        if (stat_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          stat_t s;
          s = stat_q.pop_front();
          chk("crc_ok", {31'd0, crc_ok}, {31'd0, s.ok});
          chk("len", {21'd0, len}, {21'd0, s.len});
          chk("err_short", {31'd0, err_short}, {31'd0, s.es});
          chk("err_long", {31'd0, err_long}, {31'd0, s.el});
          chk("done_with_last", {31'd0, out_valid & out_last}, {31'd0, s.pl});
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends pkt[0..n-1]; byte i>=2 makes byte i-2 come out.
  task automatic send_pkt(input int n, input bit gaps, input bit with_last,
                          input bit abort_after, input stat_t st);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = pkt[i];
      in_last  = with_last && (i == n - 1);
      in_abort = 1'b0;
      if (i >= 2) byte_q.push_back({pkt[i-2], in_last});
      if (in_last) stat_q.push_back(st);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (gaps) idle(1);
    end
    if (abort_after) begin
      in_valid = 1'b1;
      in_data  = 8'hAA;
      in_last  = 1'b1;
      in_abort = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_abort = 1'b0;
    end
  endtask

  task automatic load_s1(input logic [7:0] last_byte);
    pkt.delete();
    for (int i = 0; i < 9; i++) pkt.push_back(8'h31 + 8'(i));
    pkt.push_back(8'hC8);
    pkt.push_back(last_byte);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_data"},  {24'd0, out_data},  32'd0);
    chk({tag, "_out_last"},  {31'd0, out_last},  32'd0);
    chk({tag, "_done"},      {31'd0, done},      32'd0);
    chk({tag, "_crc_ok"},    {31'd0, crc_ok},    32'd0);
    chk({tag, "_len"},       {21'd0, len},       32'd0);
    chk({tag, "_err_short"}, {31'd0, err_short}, 32'd0);
    chk({tag, "_err_long"},  {31'd0, err_long},  32'd0);
  endtask

  initial begin
    stat_t s1;
    logic [15:0] c;
    s1 = '{ok: 1'b1, len: 11'd9, es: 1'b0, el: 1'b0, pl: 1'b1};
    in_valid = 1'b0; in_last = 1'b0; in_abort = 1'b0; in_data = 8'h00;
    reset_L = 1'b1;
    #1 reset_L = 1'b0;
    #3 chk_all_zero("reset");
    #16 reset_L = 1'b1;
    idle(2);

    // "123456789" with good CRC
    load_s1(8'hB4);
    send_pkt(11, 1'b0, 1'b1, 1'b0, s1);
    idle(2);

    // corrupted CRC
    load_s1(8'hB5);
    send_pkt(11, 1'b0, 1'b1, 1'b0, '{ok: 1'b0, len: 11'd9, es: 1'b0, el: 1'b0, pl: 1'b1});
    idle(2);

    // zero-length payload, then 1-byte packet back-to-back
    pkt.delete(); pkt.push_back(8'h00); pkt.push_back(8'h00);
    send_pkt(2, 1'b0, 1'b1, 1'b0, '{ok: 1'b1, len: 11'd0, es: 1'b0, el: 1'b0, pl: 1'b0});
    pkt.delete(); pkt.push_back(8'h12);
    send_pkt(1, 1'b0, 1'b1, 1'b0, '{ok: 1'b0, len: 11'd0, es: 1'b1, el: 1'b0, pl: 1'b0});
    idle(2);

    // abort after 5 bytes; status must keep the short-packet values
    pkt.delete();
    for (int i = 1; i <= 5; i++) pkt.push_back(8'(i));
    send_pkt(5, 1'b0, 1'b0, 1'b1, s1);
    idle(3);
    chk("abort_held_crc_ok", {31'd0, crc_ok}, 32'd0);
    chk("abort_held_err_short", {31'd0, err_short}, 32'd1);
    chk("abort_held_len", {21'd0, len}, 32'd0);
    chk("abort_no_pending", byte_q.size(), 32'd0);
    load_s1(8'hB4);
    send_pkt(11, 1'b1, 1'b1, 1'b0, s1);
    idle(2);

    // 1100-byte payload: saturating length
    pkt.delete();
    c = 16'hFFFF;
    for (int i = 0; i < 1100; i++) begin
      pkt.push_back(8'(i * 7 + 3));
      c = crc_upd(c, 8'(i * 7 + 3));
    end
    pkt.push_back(~c[7:0]);
    pkt.push_back(~c[15:8]);
    send_pkt(1102, 1'b0, 1'b1, 1'b0, '{ok: 1'b1, len: 11'd1023, es: 1'b0, el: 1'b1, pl: 1'b1});
    idle(2);
    chk("long_status_held", {30'd0, crc_ok, err_long}, 32'd3);

    // reset mid-packet
    load_s1(8'hB4);
    send_pkt(6, 1'b0, 1'b0, 1'b0, s1);
    @(negedge clk);
    #2 reset_L = 1'b0;
    #1 chk_all_zero("midreset");
    #4 reset_L = 1'b1;
    idle(2);
    send_pkt(11, 1'b0, 1'b1, 1'b0, s1);
    idle(3);

    chk("bytes_drained", byte_q.size(), 32'd0);
    chk("status_drained", stat_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
